// File: rtl/stage_mux.sv
// N-way WIDTH-bit selector feeding a 2-entry registered skid buffer with valid/ready on both sides.
// in_ready and out_valid are flop outputs derived from the next state.
module stage_mux #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      N         = 4,
  parameter int unsigned      SEL_W     = $clog2(N),
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_err
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic [WIDTH-1:0] sel_word;
  logic             sel_oob;
  logic             accept, pop;

  assign accept   = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign out_data = main_q;

  // Out-of-range selects fall back to word 0 and are flagged.
  always_comb begin
    sel_word = in_data[WIDTH-1:0];
    sel_oob  = 1'b1;
    for (int i = 0; i < int'(N); i++) begin
      if (sel == SEL_W'(i)) begin
        sel_word = in_data[i*WIDTH +: WIDTH];
        sel_oob  = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StEmpty: if (accept) state_d = StOne;
      StOne: begin
        if (accept && !pop)      state_d = StFull;
        else if (!accept && pop) state_d = StEmpty;
      end
      StFull:  if (pop) state_d = StOne;
      default: state_d = StEmpty;
    endcase
    if (flush) state_d = StEmpty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StEmpty;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      main_q    <= RESET_VAL;
      skid_q    <= '0;
      sel_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d != StFull);
      out_valid <= (state_d != StEmpty);
      if (accept && sel_oob) sel_err <= 1'b1;
      // A flush discards the incoming word and leaves main_q holding its last value.
      if (!flush) begin
        if (state_q == StFull) begin
          if (pop) main_q <= skid_q;
        end else if (accept) begin
          if (state_q == StOne && !pop) skid_q <= sel_word;
          else                          main_q <= sel_word;
        end
      end
    end
  end

endmodule
